// File: rtl/alu_sequencer.sv
// Request/response sequencer in front of a single-cycle ALU: latches operands,
// screens illegal opcodes and zero divisors, and holds the result until taken.
module alu_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_tmp1,
  output logic [WIDTH-1:0] alu_tmp2,
  output logic [2:0]       alu_op,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             sticky_carry,
  input  logic             sticky_clr,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge, and ready
  // is only ever high in the state that can take the transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  // The attached ALU answers in one cycle; an error is forced only if that
  // would exceed the allowed EXEC wait.
  localparam int unsigned ALU_LATENCY  = 1;
  localparam logic        EXEC_OVERRUN = (ALU_LATENCY > TIMEOUT);

  state_t state;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      alu_tmp1     <= '0;
      alu_tmp2     <= '0;
      alu_op       <= '0;
      alu_enable   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_err      <= 1'b0;
      sticky_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_tmp1  <= req_a;
            alu_tmp2  <= req_b;
            alu_op    <= req_op;
            req_ready <= 1'b0;
            if (req_op > OP_MOD) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
            end else if (((req_op == OP_DIV) || (req_op == OP_MOD)) && (req_b == '0)) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_zero   <= 1'b1;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
            end else begin
              state      <= EXEC;
              alu_enable <= 1'b1;
            end
          end
        end
        EXEC: begin
          state      <= RESP;
          alu_enable <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_carry  <= alu_carry;
          rsp_err    <= EXEC_OVERRUN;
        end
        RESP: begin
          // req_ready returns only after the handshake edge, so a new request
          // can never be taken in the same cycle a response leaves.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          alu_enable <= 1'b0;
          rsp_valid  <= 1'b0;
        end
      endcase

      // A carrying handshake beats a simultaneous clear.
      if (rsp_valid && rsp_ready && rsp_carry) begin
        sticky_carry <= 1'b1;
      end else if (sticky_clr) begin
        sticky_carry <= 1'b0;
      end
    end
  end

endmodule
